// File: rtl/int_ext_arbiter.sv
// Round-robin shared sign/zero-extension unit for integer literal producers.
// One registered result slot; widens 1/2/8/16/32/64-bit values to OW bits.
module int_ext_arbiter #(
    parameter int NREQ = 4,
    parameter int OW   = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*64-1:0]        req_data,
    input  logic [NREQ*3-1:0]         req_type,
    input  logic [NREQ-1:0]           req_signed,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OW-1:0]             out_data,
    output logic [$clog2(NREQ)-1:0]   out_src,
    output logic                      out_all_ones,
    output logic                      out_err,
    output logic [7:0]                err_count
);

    localparam int SW = $clog2(NREQ);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] grant;
    logic          found;
    logic          slot_free;
    logic          xfer;
    logic [63:0]   sel_data;
    logic [2:0]    sel_type;
    logic          sel_signed;
    logic [63:0]   lo_mask;
    logic          msb;
    logic          ext_err;
    logic          ext_ones;
    logic [OW-1:0] ext;

    assign slot_free = (state == EMPTY) || (out_ready && out_valid);

    // Scan from ptr upward, wrapping, for the first valid requester.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                grant = SW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && slot_free && found)
            req_ready[grant] = 1'b1;
    end

    assign xfer       = |(req_valid & req_ready);
    assign sel_data   = req_data[64*grant +: 64];
    assign sel_type   = req_type[3*grant +: 3];
    assign sel_signed = req_signed[grant];

    always_comb begin
        lo_mask = '0;
        msb     = 1'b0;
        ext_err = 1'b0;
        unique case (sel_type)
            3'd0: begin lo_mask = 64'h1;                  msb = sel_data[0];  end
            3'd1: begin lo_mask = 64'h3;                  msb = sel_data[1];  end
            3'd2: begin lo_mask = 64'hFF;                 msb = sel_data[7];  end
            3'd3: begin lo_mask = 64'hFFFF;               msb = sel_data[15]; end
            3'd4: begin lo_mask = 64'hFFFF_FFFF;          msb = sel_data[31]; end
            3'd5: begin lo_mask = 64'hFFFF_FFFF_FFFF_FFFF; msb = sel_data[63]; end
            default: ext_err = 1'b1;
        endcase
        ext = OW'(sel_data & lo_mask);
        if (sel_signed && msb)
            ext = ext | ~OW'(lo_mask);
        ext_ones = !ext_err && (ext == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= EMPTY;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_src      <= '0;
            out_all_ones <= 1'b0;
            out_err      <= 1'b0;
            err_count    <= '0;
            ptr          <= '0;
        end else if (xfer) begin
            state        <= FULL;
            out_valid    <= 1'b1;
            out_data     <= ext;
            out_src      <= grant;
            out_all_ones <= ext_ones;
            out_err      <= ext_err;
            ptr          <= (grant == SW'(NREQ-1)) ? '0 : grant + 1'b1;
            if (ext_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end else if (out_valid && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_int_ext_arbiter.sv
// Scoreboard bench for int_ext_arbiter: directed vectors, queued expectations,
// monitor compares each result as the downstream consumes it.
module tb_int_ext_arbiter;

    localparam int NREQ = 4;
    localparam int OW   = 128;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*64-1:0] req_data;
    logic [NREQ*3-1:0] req_type;
    logic [NREQ-1:0]   req_signed;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic [1:0]        out_src;
    logic              out_all_ones;
    logic              out_err;
    logic [7:0]        err_count;

    typedef struct packed {
        logic [127:0] d;
        logic [1:0]   s;
        logic         a;
        logic         e;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int failed   = 0;

    localparam logic [127:0] ONES = '1;

    int_ext_arbiter #(.NREQ(NREQ), .OW(OW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_type(req_type), .req_signed(req_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src),
        .out_all_ones(out_all_ones), .out_err(out_err),
        .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            compared++;
            if (q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_result got data=%h src=%0d", out_data, out_src);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_data !== e.d || out_src !== e.s ||
                    out_all_ones !== e.a || out_err !== e.e) begin
                    failed++;
                    $display("FAIL result got data=%h src=%0d ones=%b err=%b want data=%h src=%0d ones=%b err=%b",
                             out_data, out_src, out_all_ones, out_err, e.d, e.s, e.a, e.e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    task automatic setreq(input int i, input logic [2:0] t, input logic s, input logic [63:0] d);
        req_data[64*i +: 64] = d;
        req_type[3*i +: 3]   = t;
        req_signed[i]        = s;
    endtask

    task automatic push(input logic [127:0] d, input logic [1:0] s, input logic a, input logic e);
        exp_t x;
        x.d = d; x.s = s; x.a = a; x.e = e;
        q.push_back(x);
    endtask

    task automatic send(input int i, input logic [2:0] t, input logic s, input logic [63:0] d);
        setreq(i, t, s, d);
        req_valid    = '0;
        req_valid[i] = 1'b1;
        tick();
        req_valid = '0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '1;
        req_data   = '0;
        req_type   = '0;
        req_signed = '0;
        out_ready  = 1'b1;
        tick();
        tick();
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_data", out_data, 128'd0);
        chk("reset_out_src", 128'(out_src), 128'd0);
        chk("reset_all_ones", 128'(out_all_ones), 128'd0);
        chk("reset_err", 128'(out_err), 128'd0);
        chk("reset_err_count", 128'(err_count), 128'd0);
        chk("reset_req_ready", 128'(req_ready), 128'd0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Width and signedness vectors; requester order keeps ptr at 0 after each group.
        push(ONES, 2'd0, 1'b1, 1'b0);
        send(0, 3'd2, 1'b1, 64'hFF);
        tick();
        chk("drain_out_valid", 128'(out_valid), 128'd0);
        push(128'hFF, 2'd1, 1'b0, 1'b0);
        send(1, 3'd2, 1'b0, 64'hFF);
        push(ONES, 2'd2, 1'b1, 1'b0);
        send(2, 3'd5, 1'b1, '1);
        push({64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 2'd3, 1'b0, 1'b0);
        send(3, 3'd5, 1'b0, '1);
        push(ONES, 2'd0, 1'b1, 1'b0);
        send(0, 3'd0, 1'b1, 64'h1);
        push(128'h1, 2'd1, 1'b0, 1'b0);
        send(1, 3'd0, 1'b0, 64'h1);
        push(~128'h1, 2'd2, 1'b0, 1'b0);
        send(2, 3'd1, 1'b1, 64'h6);
        push({112'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'h8001}, 2'd3, 1'b0, 1'b0);
        send(3, 3'd3, 1'b1, 64'h1234_8001);
        push(128'h7FFF_FFFF, 2'd0, 1'b0, 1'b0);
        send(0, 3'd4, 1'b1, 64'hFFFF_FFFF_7FFF_FFFF);
        push(128'h8000_0000, 2'd1, 1'b0, 1'b0);
        send(1, 3'd4, 1'b0, 64'h8000_0000);
        push(128'h8001, 2'd2, 1'b0, 1'b0);
        send(2, 3'd3, 1'b0, 64'hFFFF_8001);
        push(128'h3, 2'd3, 1'b0, 1'b0);
        send(3, 3'd1, 1'b0, 64'h7);

        // Round robin with all requesters held valid, then with requester 1 dropped.
        for (int i = 0; i < NREQ; i++)
            setreq(i, 3'd2, 1'b0, 64'(16 + i));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                push(128'(16 + i), 2'(i), 1'b0, 1'b0);
        req_valid = 4'b1111;
        repeat (8) tick();
        for (int r = 0; r < 2; r++) begin
            push(128'h10, 2'd0, 1'b0, 1'b0);
            push(128'h12, 2'd2, 1'b0, 1'b0);
            push(128'h13, 2'd3, 1'b0, 1'b0);
        end
        req_valid = 4'b1101;
        repeat (6) tick();
        req_valid = '0;
        tick();

        // Backpressure: hold a result from requester 2, then release.
        out_ready = 1'b0;
        push({96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h8000_0000}, 2'd2, 1'b0, 1'b0);
        send(2, 3'd4, 1'b1, 64'h8000_0000);
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold_valid", 128'(out_valid), 128'd1);
            chk("hold_data", out_data, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h8000_0000});
            chk("hold_src", 128'(out_src), 128'd2);
            chk("hold_req_ready", 128'(req_ready), 128'd0);
        end
        push(128'h13, 2'd3, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        req_valid = '0;
        chk("refill_src", 128'(out_src), 128'd3);
        tick();

        // Reserved codes and saturation of the error counter.
        push(128'd0, 2'd1, 1'b0, 1'b1);
        send(1, 3'd6, 1'b0, 64'hABCD);
        chk("err_count_one", 128'(err_count), 128'd1);
        for (int i = 0; i < 300; i++)
            push(128'd0, 2'd0, 1'b0, 1'b1);
        setreq(0, 3'd7, 1'b1, '1);
        req_valid = 4'b0001;
        repeat (300) tick();
        req_valid = '0;
        tick();
        chk("err_count_sat", 128'(err_count), 128'd255);

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        send(3, 3'd2, 1'b0, 64'h5A);
        chk("full_before_rst", 128'(out_valid), 128'd1);
        req_valid = 4'b1111;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 128'(out_valid), 128'd0);
        chk("async_rst_err_count", 128'(err_count), 128'd0);
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        tick();
        req_valid = '0;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        push({120'hFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 8'h80}, 2'd2, 1'b0, 1'b0);
        send(2, 3'd2, 1'b1, 64'h80);

        for (int c = 0; c < 20 && q.size() != 0; c++)
            tick();
        chk("scoreboard_empty", 128'(q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
